// File: rtl/baby_pkg.sv
// Shared constants and FSM state type for the baby_dispstore display store.
package baby_pkg;
  localparam int WORD_W  = 32;
  localparam int ROW_W   = 5;
  localparam int ACC_ROW = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;
endpackage

// File: rtl/baby_toggle_evt.sv
// Turns a level-toggle input into one event per edge and holds its payload
// in a one-deep pending slot; ovf_o is sticky when a pending event is lost.
module baby_toggle_evt #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tog_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              commit_i,
  output logic              pend_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ovf_o
);
  logic              tog_q;
  logic              evt;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] data_q;

  assign evt = tog_i ^ tog_q;

  // A new event in the same cycle the slot commits simply refills it.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (evt) begin
      pend_d = 1'b1;
      if (pend_q && !commit_i) ovf_d = 1'b1;
    end else if (commit_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    tog_q <= tog_i;
    if (rst) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (evt) data_q <= data_i;
  end

  assign pend_o = pend_q;
  assign data_o = data_q;
  assign ovf_o  = ovf_q;
endmodule

// File: rtl/baby_dispstore.sv
// Display store: 32 store rows plus ACC, cleared after reset, written by
// toggle events, read by a 2-cycle pixel pipeline. BABY_CI_MARKER_EN adds the CI marker.
module baby_dispstore
  import baby_pkg::*;
#(
  parameter int MARK_DIV = 25000000,
  parameter int CLR_ROWS = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update,
  input  logic [WORD_W-1:0] updatedata,
  input  logic [ROW_W-1:0]  updateaddr,
  input  logic              updateACC,
  input  logic [WORD_W-1:0] newACC,
  input  logic [ROW_W-1:0]  rCI,
  input  logic              pix_req,
  input  logic [5:0]        pix_row,
  input  logic [4:0]        pix_col,
  output logic              pix_valid,
  output logic              pix_on,
  output logic              pix_mark,
  output logic              ready,
  output logic              ovf
);
  localparam logic [5:0] CLR_LAST = 6'(CLR_ROWS - 1);
  localparam logic [5:0] ACC_IDX  = 6'(ACC_ROW);

  state_e                  state_q, state_d;
  logic [5:0]              clr_q, clr_d;
  logic                    clr_we;
  logic                    idle;

  logic                    st_pend, acc_pend;
  logic                    st_ovf, acc_ovf;
  logic [ROW_W+WORD_W-1:0] st_slot;
  logic [WORD_W-1:0]       acc_slot;

  logic [WORD_W-1:0]       store_q [32];
  logic [WORD_W-1:0]       acc_q;
  logic                    st_we, acc_we;
  logic [ROW_W-1:0]        st_waddr;
  logic [WORD_W-1:0]       st_wdata, acc_wdata;

  logic                    on_d, mark_d;
  logic                    vld_p1_q, on_p1_q, mark_p1_q;
  logic                    pix_valid_q, pix_on_q, pix_mark_q;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_q == CLR_LAST) state_d = ST_IDLE;
        else                   clr_d   = clr_q + 6'd1;
      end
      ST_IDLE: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  baby_toggle_evt #(.DATA_W(ROW_W + WORD_W)) u_upd_evt (
    .clk      (clk),
    .rst      (reset),
    .tog_i    (update),
    .data_i   ({updateaddr, updatedata}),
    .commit_i (idle),
    .pend_o   (st_pend),
    .data_o   (st_slot),
    .ovf_o    (st_ovf)
  );

  baby_toggle_evt #(.DATA_W(WORD_W)) u_acc_evt (
    .clk      (clk),
    .rst      (reset),
    .tog_i    (updateACC),
    .data_i   (newACC),
    .commit_i (idle),
    .pend_o   (acc_pend),
    .data_o   (acc_slot),
    .ovf_o    (acc_ovf)
  );

  // Clear owns the write ports until IDLE; store and ACC commit independently.
  always_comb begin
    st_we     = 1'b0;
    st_waddr  = '0;
    st_wdata  = '0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    if (!reset) begin
      if (clr_we) begin
        if (clr_q < ACC_IDX) begin
          st_we    = 1'b1;
          st_waddr = clr_q[ROW_W-1:0];
        end else if (clr_q == ACC_IDX) begin
          acc_we = 1'b1;
        end
      end else if (idle) begin
        st_we     = st_pend;
        st_waddr  = st_slot[WORD_W +: ROW_W];
        st_wdata  = st_slot[WORD_W-1:0];
        acc_we    = acc_pend;
        acc_wdata = acc_slot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (st_we)  store_q[st_waddr] <= st_wdata;
    if (acc_we) acc_q             <= acc_wdata;
  end

  // Lookup in the request cycle, so a same-cycle commit is not yet visible.
  always_comb begin
    on_d = 1'b0;
    if (idle) begin
      if (pix_row < ACC_IDX)       on_d = store_q[pix_row[ROW_W-1:0]][pix_col];
      else if (pix_row == ACC_IDX) on_d = acc_q[pix_col];
    end
  end

`ifdef BABY_CI_MARKER_EN
  localparam int CNT_W = (MARK_DIV > 1) ? $clog2(MARK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_W'(MARK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign mark_d = idle && phase_q && (pix_row == {1'b0, rCI});
`else
  logic unused_mark;
  assign unused_mark = (^rCI) ^ (MARK_DIV > 0);
  assign mark_d      = 1'b0;
`endif

  // Stage 1: lookup result registered
  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= pix_req;
    on_p1_q   <= on_d;
    mark_p1_q <= mark_d;
  end

  // Stage 2: output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_on_q    <= 1'b0;
      pix_mark_q  <= 1'b0;
    end else begin
      pix_valid_q <= vld_p1_q;
      pix_on_q    <= on_p1_q;
      pix_mark_q  <= mark_p1_q;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_on    = pix_on_q;
  assign pix_mark  = pix_mark_q;
  assign ready     = idle;
  assign ovf       = st_ovf | acc_ovf;
endmodule

// File: tb/tb_baby_dispstore.sv
// Scoreboard bench for baby_dispstore: reads push expected pixels, a negedge
// monitor pops and checks them; control outputs are checked inline.
module tb_baby_dispstore;
  logic        clk = 1'b0;
  logic        reset;
  logic        update, updateACC;
  logic [31:0] updatedata, newACC;
  logic [4:0]  updateaddr, rCI;
  logic        pix_req;
  logic [5:0]  pix_row;
  logic [4:0]  pix_col;
  logic        pix_valid, pix_on, pix_mark, ready, ovf;

  typedef struct {
    bit o;
    bit m;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  baby_dispstore #(.MARK_DIV(4), .CLR_ROWS(33)) dut (
    .clk        (clk),
    .reset      (reset),
    .update     (update),
    .updatedata (updatedata),
    .updateaddr (updateaddr),
    .updateACC  (updateACC),
    .newACC     (newACC),
    .rCI        (rCI),
    .pix_req    (pix_req),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_valid  (pix_valid),
    .pix_on     (pix_on),
    .pix_mark   (pix_mark),
    .ready      (ready),
    .ovf        (ovf)
  );

  // Cycles since the last reset edge; clear finishes at cycle 33.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit exp_mark(input int row);
`ifdef BABY_CI_MARKER_EN
    return (cyc >= 33) && (row == 2) && (((cyc / 4) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int row, input int col, input bit exp_on);
    exp_t e;
    pix_req = 1'b1;
    pix_row = 6'(row);
    pix_col = 5'(col);
    e.o   = exp_on;
    e.m   = exp_mark(row);
    e.due = cyc + 2;
    sb.push_back(e);
    step();
    pix_req = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int g = 0;
    while (!ready && g < 200) begin
      step();
      g++;
    end
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_cycles"}, cyc, 32'd33);
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 20) begin
      step();
      g++;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected", 32'(pix_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_on",   32'(pix_on),   32'(e.o));
        chk("rd_mark", 32'(pix_mark), 32'(e.m));
        chk("rd_lat",  cyc,           e.due);
      end
    end
  end

  initial begin
    reset = 1'b1; update = 1'b0; updateACC = 1'b0;
    updatedata = '0; updateaddr = '0; newACC = '0; rCI = 5'd2;
    pix_req = 1'b0; pix_row = '0; pix_col = '0;
    step();
    chk("rst_ready", 32'(ready),     32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_on",    32'(pix_on),    32'd0);
    chk("rst_mark",  32'(pix_mark),  32'd0);
    chk("rst_ovf",   32'(ovf),       32'd0);
    reset = 1'b0;
    wait_ready("clr1");

    // Every row, including ACC and a blank row, reads zero after clear.
    for (int r = 0; r <= 32; r++) rd(r, (r * 7) % 32, 1'b0);
    rd(40, 3, 1'b0);

    updateaddr = 5'd5; updatedata = 32'h8000_0001; update = ~update;
    step(); step();
    rd(5, 0, 1'b1); rd(5, 31, 1'b1); rd(5, 1, 1'b0);

    updateaddr = 5'd3; updatedata = 32'h0000_000F; newACC = 32'h1;
    update = ~update; updateACC = ~updateACC;
    step(); step();
    for (int c = 0; c < 5; c++) rd(3, c, c < 4);
    rd(32, 0, 1'b1); rd(32, 1, 1'b0);
    chk("ovf_simul", 32'(ovf), 32'd0);

    // Read in the commit cycle sees old row 9; the next read sees the write.
    updateaddr = 5'd9; updatedata = 32'hFFFF_FFFF; update = ~update;
    step();
    rd(9, 7, 1'b0); rd(9, 7, 1'b1); rd(9, 0, 1'b1); rd(9, 31, 1'b1);

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) rd(2, 4, 1'b0);
      else            rd(6, 0, 1'b0);
    end
    drain();

    // Two events during clear: the second overwrites the slot and sets ovf.
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_ovf",   32'(ovf),   32'd0);
    chk("rst2_ready", 32'(ready), 32'd0);
    updateaddr = 5'd7; updatedata = 32'h1; update = ~update;
    step();
    updatedata = 32'h2; update = ~update;
    step();
    rd(5, 0, 1'b0); rd(9, 3, 1'b0);
    chk("ovf_lost", 32'(ovf), 32'd1);
    wait_ready("clr2");
    step(); step();
    rd(7, 0, 1'b0); rd(7, 1, 1'b1); rd(7, 2, 1'b0);
    rd(5, 0, 1'b0); rd(9, 31, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/baby_dispstore.md
BABY_DISPSTORE -- requirements
Module: baby_dispstore

Interface
REQ-001 The block SHALL have parameter MARK_DIV, default 25000000, meaning clock cycles per half-period of the CI marker blink.
REQ-002 The block SHALL have parameter CLR_ROWS, default 33, meaning the number of rows cleared after reset (32 store rows plus 1 ACC row).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous and active-high.
REQ-005 The block SHALL have port update, input, 1 bit: store-write toggle; any level change is one event.
REQ-006 The block SHALL have port updatedata, input, 32 bits: store-write data.
REQ-007 The block SHALL have port updateaddr, input, 5 bits: store-write row.
REQ-008 The block SHALL have port updateACC, input, 1 bit: ACC-write toggle; any level change is one event.
REQ-009 The block SHALL have port newACC, input, 32 bits: ACC-write data.
REQ-010 The block SHALL have port rCI, input, 5 bits: current CI row.
REQ-011 The block SHALL have port pix_req, input, 1 bit: pixel read request.
REQ-012 The block SHALL have port pix_row, input, 6 bits: rows 0-31 are the store; row 32 is ACC; rows 33-63 read as blank.
REQ-013 The block SHALL have port pix_col, input, 5 bits: bit index; column 0 is bit 0, at the display left.
REQ-014 The block SHALL have port pix_valid, output, 1 bit: read result valid.
REQ-015 The block SHALL have port pix_on, output, 1 bit: pixel lit.
REQ-016 The block SHALL have port pix_mark, output, 1 bit: the pixel row equals CI and the marker phase is on.
REQ-017 The block SHALL have port ready, output, 1 bit: asserted while in IDLE.
REQ-018 The block SHALL have port ovf, output, 1 bit: sticky flag set by a lost event.

Function
REQ-019 The block SHALL implement FSM states CLEAR and IDLE.
- CLEAR writes zero to rows 0..CLR_ROWS-1, one row per cycle.
- After the last clear row the FSM SHALL go to IDLE; it SHALL never leave IDLE except by reset.
REQ-020 An event SHALL be detected in the cycle where the toggle input differs from its 1-cycle-delayed copy; data and address SHALL be captured in that same cycle.
REQ-021 Each event source (store, ACC) SHALL have a one-deep pending slot.
- In IDLE, a pending write SHALL commit in the cycle after detection, so the data is visible to reads issued 2 cycles after the toggle.
REQ-022 Store and ACC events in the same cycle SHALL both commit, in the same cycle; the ACC row is a separate register.
REQ-023 Events arriving during CLEAR SHALL be held in their pending slot and committed in the first IDLE cycle.
REQ-024 A new event on a source whose slot is still pending SHALL overwrite the slot with the newer data and set ovf; ovf SHALL clear only on reset.
REQ-025 Reads SHALL have 2-cycle latency: pix_req in cycle N gives pix_valid=1 in cycle N+2, with pix_on and pix_mark for that request. Reads SHALL be fully pipelined, one per cycle.
REQ-026 A read and a commit to the same row in the same cycle SHALL return the pre-write data.
REQ-027 During CLEAR, reads SHALL return pix_on=0 and pix_mark=0, with pix_valid still asserted.
REQ-028 The marker counter SHALL wrap at MARK_DIV-1 and toggle the phase on wrap.

Reset
REQ-029 On reset the block SHALL set:
- FSM to CLEAR, clear row counter to 0;
- pending slots empty, ovf=0;
- pix_valid=0, pix_on=0, pix_mark=0, ready=0;
- marker counter and phase to 0.
REQ-030 Reset SHALL load each toggle's delayed copy with the current toggle level, so no spurious event follows reset.
REQ-031 Reset mid-CLEAR or mid-commit SHALL restart CLEAR from row 0 and discard pending events.

Configuration
REQ-032 With BABY_CI_MARKER_EN defined, pix_mark SHALL behave as in REQ-016 and REQ-028.
REQ-033 Without BABY_CI_MARKER_EN, pix_mark SHALL be constant 0 and the marker counter SHALL be absent.

Structure
REQ-034 Package baby_pkg SHALL hold: the ACC row constant (32), the word width (32), the row-address width (5) and the FSM state enum.
REQ-035 Sub-module baby_toggle_evt SHALL perform toggle-to-event detection with its one-deep pending slot and overflow output, instantiated once per source.

Verification
REQ-036 Reset held 1 cycle, then run -> ready rises exactly 33 cycles after reset deasserts; every row reads 0.
REQ-037 Toggle update with updateaddr=5, updatedata=0x80000001 in IDLE -> read row 5 columns 0 and 31 two cycles later gives pix_on=1; column 1 gives 0.
REQ-038 Toggle update and updateACC in the same cycle (row 3 = 0xF, ACC = 0x1) -> row 3 bits 0-3 are lit and row 32 bit 0 is lit; ovf=0.
REQ-039 Two update toggles 1 cycle apart during CLEAR (row 7 = 0x1, then 0x2) -> ovf=1; after ready, row 7 reads 0x2.
REQ-040 Read row 9 in the same cycle a 0xFFFFFFFF write to row 9 commits -> returns the old value; the next read returns all ones.
REQ-041 With BABY_CI_MARKER_EN defined, MARK_DIV=4, rCI=2 -> pix_mark on row 2 alternates every 4 cycles and is 0 on other rows.
